// File: rtl/sample_fifo_if.sv
// sample_fifo_if -- producer/consumer bundle for sample_fifo.
//
// Signals:
//   wr_en     producer write request
//   din       signed write sample
//   full      FIFO holds DEPTH entries
//   rd_en     consumer pop request
//   dout      signed head-of-queue sample (first-word-fall-through, zero when empty)
//   empty     FIFO holds no entries
//   count     number of stored entries (0..DEPTH)
//   overflow  sticky: write attempted while full
//   underflow sticky: read attempted while empty
//
// Modports:
//   master  the user side (drives requests and write data, observes status)
//   slave   the FIFO side
interface sample_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] din;
  logic                         full;
  logic                         rd_en;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         empty;
  logic [CW-1:0]                count;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output wr_en, din, rd_en,
    input  full, dout, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output full, dout, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo -- synchronous first-word-fall-through FIFO for signed samples.
//
// Ports:
//   clock  single clock, all state updates on its rising edge
//   reset  asynchronous active-high reset (pointers, count, sticky flags)
//   bus    sample_fifo_if.slave: wr_en/din/full, rd_en/dout/empty,
//          count, overflow, underflow
//
// Storage is a plain array with no reset; after reset count is zero, so any
// stale contents stay hidden behind empty until a fresh write lands there.
module sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input logic          clock,
  input logic          reset,
  sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full_w, empty_w;
  logic wr_accept, rd_accept;

  // Status comes straight from the registered count, so full and empty can
  // never be high together.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  always_comb begin
    // Acceptance is judged on the current (pre-edge) state: a simultaneous
    // read on a full FIFO does not make room for the write in the same edge,
    // and a simultaneous write on an empty FIFO does not feed the read.
    wr_accept   = bus.wr_en && !full_w && !reset;
    rd_accept   = bus.rd_en && !empty_w && !reset;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (bus.wr_en & full_w);
    underflow_d = underflow_q | (bus.rd_en & empty_w);

    // Pointers are exactly log2(DEPTH) bits, so DEPTH-1 wraps to 0 naturally.
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.din;
  end

  // Head of queue is visible combinationally; forced to zero while empty so
  // unwritten or discarded entries never leak out.
  assign bus.dout      = empty_w ? '0 : mem_q[rd_ptr_q];
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of one signed sample word.
REQ-002 Parameter DEPTH, 16, number of storage entries; SHALL be a power of two, at least 2.
REQ-003 clock  input  1  single clock for all logic; all sequential state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  producer write request.
REQ-006 din  input  DATA_WIDTH  write data, signed.
REQ-007 full  output  1  high when count equals DEPTH.
REQ-008 rd_en  input  1  consumer read (pop) request.
REQ-009 dout  output  DATA_WIDTH  head-of-queue data, signed, first-word-fall-through.
REQ-010 empty  output  1  high when count equals 0.
REQ-011 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 overflow  output  1  sticky flag: write attempted while full.
REQ-013 underflow  output  1  sticky flag: read attempted while empty.

Function
REQ-014 Write accepted on a rising edge iff wr_en=1 and full=0; din stored at write pointer; write pointer advances by 1.
REQ-015 Read accepted on a rising edge iff rd_en=1 and empty=0; read pointer advances by 1.
REQ-016 dout SHALL be combinational: entry at read pointer when empty=0, all zeros when empty=1; no read latency (consumer samples dout in the same cycle it asserts rd_en).
REQ-017 A written word SHALL appear on dout no earlier than the cycle after its write edge, and empty SHALL deassert in that cycle.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-019 count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-020 Simultaneous wr_en and rd_en while full: read accepted, write rejected (full gates write on current state), count becomes DEPTH-1, overflow set.
REQ-021 Simultaneous wr_en and rd_en while empty: write accepted, read rejected, count becomes 1, underflow set.
REQ-022 Simultaneous accepted write and read with 0<count<DEPTH: both occur, count unchanged, FIFO order preserved.
REQ-023 full and empty SHALL be derived from registered count, never both high.
REQ-024 overflow SHALL set on any edge with wr_en=1 and full=1; underflow on any edge with rd_en=1 and empty=1; both hold until reset.
REQ-025 Rejected requests SHALL not alter storage, pointers or count.
REQ-026 Data SHALL pass bit-exact; no arithmetic on samples.

Reset
REQ-027 On reset assertion, immediately and regardless of clock: pointers 0, count 0, empty 1, full 0, dout 0, overflow 0, underflow 0.
REQ-028 Storage array is not reset; its contents SHALL be unobservable until rewritten.
REQ-029 Reset mid-operation SHALL discard all stored entries; first post-reset write SHALL be first word read.
REQ-030 While reset is high, wr_en and rd_en SHALL be ignored.

Verification
REQ-031 Reset, write 0x00000005 once -> next cycle empty=0, dout=0x00000005, count=1; pop -> empty=1, dout=0, count=0.
REQ-032 Write 16 words 0..15 (DEPTH=16) -> full=1, count=16; 17th write -> overflow=1, contents unchanged; drain -> 0..15 in order.
REQ-033 Continuous write+read for 40 cycles with count=3 -> count stays 3, outputs in order across two pointer wraps.
REQ-034 Full, assert wr_en and rd_en together -> count=15, full=0, overflow=1; empty, assert both -> count=1, underflow=1.
REQ-035 Fill 8 entries, assert reset asynchronously mid-cycle -> outputs reach reset values before next edge; next write 0xFFFFFFF0 read back as first word.
REQ-036 Signed extremes 0x80000000 and 0x7FFFFFFF written and read -> bit-exact on dout.
